cfg_loader: RTL and testbench



---
 rtl/cfg_loader_pkg.sv | 24 ++
 rtl/cfg_word_buf.sv | 35 +++
 rtl/cfg_loader.sv | 198 +++++++++++++++++++
 tb/tb_cfg_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared types and helpers for the configuration frame loader.
// Holds the FSM state enum, header field offsets and counter width helpers.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ID,
        PAY
    } state_e;

    localparam int HDR_LEN_LSB = 16;

    // Width of the outstanding payload-word counter.
    function automatic int fetch_cnt_w(int len_w, int data_w);
        return len_w - $clog2(data_w) + 1;
    endfunction

    // Width of the ID bit index.
    function automatic int id_idx_w(int id_w);
        return $clog2(id_w + 1);
    endfunction

endpackage

// File: rtl/cfg_word_buf.sv
// cfg_word_buf: one-entry holding register with valid/ready on both sides.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module cfg_word_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  full;
    logic [DATA_WIDTH-1:0] data;

    assign in_ready  = ~full;
    assign out_valid = full;
    assign out_data  = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (out_ready && full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: turns a header word plus payload words into a gap-free serial
// config frame (ID MSB first, then payload LSB first). Ports: clk, crst_n,
// in_data/in_valid/in_ready, cfg_out_start, cfg_bit_out, busy, done, underrun.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  crst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_out_start,
    output logic                  cfg_bit_out,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int LW = $clog2(DATA_WIDTH);
    localparam int FW = fetch_cnt_w(LEN_WIDTH, DATA_WIDTH);
    localparam int XW = id_idx_w(ID_WIDTH);

    state_e                state_q, state_n;
    logic [ID_WIDTH-1:0]   id_q, id_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n, cnt_q, cnt_n, shown;
    logic [FW-1:0]         wf_q, wf_n;
    logic [XW-1:0]         idx_q, idx_n;
    logic [DATA_WIDTH-1:0] sr_q, sr_n;
    logic ready_n, start_n, bit_n, busy_n, done_n, urun_n;
    logic hs, adv, bound, byp;
    logic buf_push, buf_pop, buf_valid, buf_ready, buf_full_n;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [ID_WIDTH-1:0]   hdr_id;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [FW-1:0]         hdr_words;

    assign hs        = in_valid & in_ready;
    assign hdr_id    = in_data[ID_WIDTH-1:0];
    assign hdr_len   = in_data[HDR_LEN_LSB +: LEN_WIDTH];
    assign hdr_words = FW'(hdr_len >> LW) + FW'(|hdr_len[LW-1:0]);
    // Index of the next payload bit; word 0 is preloaded so index 0 is no boundary.
    assign shown     = len_q - cnt_q;
    assign bound     = (shown[LW-1:0] == '0) && (shown != '0);

    cfg_word_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (crst_n),
        .in_valid  (buf_push),
        .in_ready  (buf_ready),
        .in_data   (in_data),
        .out_valid (buf_valid),
        .out_ready (buf_pop),
        .out_data  (buf_data)
    );

    always_comb begin
        state_n = state_q;
        id_n    = id_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        wf_n    = wf_q;
        idx_n   = idx_q;
        sr_n    = sr_q;
        start_n = 1'b0;
        bit_n   = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        urun_n  = underrun;
        adv     = 1'b0;
        byp     = 1'b0;
        buf_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    id_n   = hdr_id;
                    len_n  = hdr_len;
                    cnt_n  = hdr_len;
                    wf_n   = hdr_words;
                    urun_n = 1'b0;
                    busy_n = 1'b1;
                    if (hdr_len == '0) begin
                        state_n = ID;
                        start_n = 1'b1;
                        bit_n   = hdr_id[ID_WIDTH-1];
                        idx_n   = XW'(ID_WIDTH - 1);
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                if (hs) begin
                    sr_n    = in_data;
                    wf_n    = wf_q - FW'(1);
                    state_n = ID;
                    start_n = 1'b1;
                    bit_n   = id_q[ID_WIDTH-1];
                    idx_n   = XW'(ID_WIDTH - 1);
                end
            end
            ID: begin
                if (idx_q != '0) begin
                    idx_n = idx_q - XW'(1);
                    bit_n = id_q[idx_n];
                end else if (len_q != '0) begin
                    state_n = PAY;
                    adv     = 1'b1;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            PAY: begin
                if (cnt_q != '0) begin
                    adv = 1'b1;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (hs && (state_q == ID || state_q == PAY)) begin
            wf_n = wf_q - FW'(1);
        end

        if (adv) begin
            cnt_n = cnt_q - LEN_WIDTH'(1);
            if (!bound) begin
                bit_n = sr_q[0];
                sr_n  = sr_q >> 1;
            end else if (buf_valid) begin
                bit_n   = buf_data[0];
                sr_n    = buf_data >> 1;
                buf_pop = 1'b1;
            end else if (hs) begin
                // Word lands exactly on the boundary: use it directly.
                bit_n = in_data[0];
                sr_n  = in_data >> 1;
                byp   = 1'b1;
            end else begin
                // Missing word: send zeros and count it as fetched.
                urun_n = 1'b1;
                sr_n   = '0;
                wf_n   = wf_q - FW'(1);
            end
        end

        buf_push = hs && !byp && buf_ready &&
                   (state_q == ID || state_q == PAY);
        buf_full_n = buf_push | (buf_valid & ~buf_pop);
        if (state_n == IDLE || state_n == FETCH) begin
            ready_n = 1'b1;
        end else begin
            ready_n = !buf_full_n && (wf_n != '0);
        end
    end

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            state_q       <= IDLE;
            id_q          <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            wf_q          <= '0;
            idx_q         <= '0;
            sr_q          <= '0;
            in_ready      <= 1'b0;
            cfg_out_start <= 1'b0;
            cfg_bit_out   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state_q       <= state_n;
            id_q          <= id_n;
            len_q         <= len_n;
            cnt_q         <= cnt_n;
            wf_q          <= wf_n;
            idx_q         <= idx_n;
            sr_q          <= sr_n;
            in_ready      <= ready_n;
            cfg_out_start <= start_n;
            cfg_bit_out   <= bit_n;
            busy          <= busy_n;
            done          <= done_n;
            underrun      <= urun_n;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed scoreboard bench for cfg_loader.
// Stimulus queues the expected bit stream; a negedge monitor checks it.
module tb_cfg_loader;

    logic        clk = 1'b0;
    logic        crst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, cfg_out_start, cfg_bit_out;
    logic        busy, done, underrun;

    cfg_loader #(
        .DATA_WIDTH (32),
        .ID_WIDTH   (3),
        .LEN_WIDTH  (12)
    ) dut (
        .clk           (clk),
        .crst_n        (crst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic fin;
        logic st;
        logic b;
        logic ur;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [2:0] id, input int len);
        logic [31:0] l;
        l = len;
        return {4'b0, l[11:0], 13'b0, id};
    endfunction

    task automatic push_frame(input logic [2:0] id, input int len,
                              input logic [63:0] pay, input logic ur);
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{1'b0, (i == 0), id[2-i], 1'b0});
        for (int j = 0; j < len; j++)
            exp_q.push_back('{1'b0, 1'b0, pay[j], 1'b0});
        exp_q.push_back('{1'b1, 1'b0, 1'b0, ur});
    endtask

    task automatic send(input logic [31:0] d);
        int k = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!crst_n) begin
            active = 1'b0;
        end else begin
            if (cfg_out_start) active = 1'b1;
            if (active) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                    active = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.fin) begin
                        chk("done_cycle",
                            32'({done, busy, underrun, in_ready,
                                 cfg_out_start, cfg_bit_out}),
                            32'({1'b1, 1'b0, mon_e.ur, 1'b1, 1'b0, 1'b0}));
                        active = 1'b0;
                    end else begin
                        chk("stream_bit",
                            32'({cfg_out_start, cfg_bit_out, busy}),
                            32'({mon_e.st, mon_e.b, 1'b1}));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Values held in reset
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", cfg_out_start, 0);
        chk("rst_bit", cfg_bit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk);
        crst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // Minimal frame: id=5, len=0 -> 1,0,1
        push_frame(3'd5, 0, 64'h0, 1'b0);
        send(hdr(3'd5, 0));
        drain(50);

        // Single word: id=2, len=8, 0xA5
        push_frame(3'd2, 8, 64'hA5, 1'b0);
        send(hdr(3'd2, 8));
        send(32'h0000_00A5);
        chk("ready_low_after_pay", in_ready, 0);
        drain(50);

        // Multi-word, no stall: len=40
        push_frame(3'd3, 40, {32'h0000_003C, 32'hFFFF_FFFF}, 1'b0);
        send(hdr(3'd3, 40));
        send(32'hFFFF_FFFF);
        send(32'h0000_003C);
        drain(100);

        // Underrun: len=64, second word never taken
        push_frame(3'd6, 64, {32'h0, 32'h1234_5678}, 1'b1);
        send(hdr(3'd6, 64));
        send(32'h1234_5678);
        repeat (40) @(negedge clk);
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        repeat (5) begin
            chk("late_word_ignored", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain(100);
        chk("underrun_sticky", underrun, 1);

        // Back-to-back frames
        push_frame(3'd1, 0, 64'h0, 1'b0);
        send(hdr(3'd1, 0));
        chk("underrun_cleared", underrun, 0);
        wait_done();
        push_frame(3'd4, 0, 64'h0, 1'b0);
        send(hdr(3'd4, 0));
        @(negedge clk);
        chk("b2b_gap_len0", cfg_out_start, 1);
        wait_done();
        push_frame(3'd7, 8, 64'h96, 1'b0);
        send(hdr(3'd7, 8));
        send(32'h0000_0096);
        @(negedge clk);
        chk("b2b_gap_len8", cfg_out_start, 1);
        drain(50);

        // Reset mid-frame
        push_frame(3'd3, 40, {32'h0000_00FF, 32'hFFFF_FFFF}, 1'b0);
        send(hdr(3'd3, 40));
        send(32'hFFFF_FFFF);
        send(32'h0000_00FF);
        repeat (10) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #2 crst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_start", cfg_out_start, 0);
        chk("mid_rst_bit", cfg_bit_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        crst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", in_ready, 1);
        push_frame(3'd5, 8, 64'h5A, 1'b0);
        send(hdr(3'd5, 8));
        send(32'h0000_005A);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
